uart_rx_fifo: RTL and testbench

//  Receive buffer directly downstream of the UART receiver: captures each byte on the

---
 rtl/uart_rx_fifo_if.sv | 27 ++
 rtl/uart_rx_fifo.sv | 85 ++++++++
 tb/tb_uart_rx_fifo.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Bus bundle between the UART receive FIFO and its producer/consumer.
// The producer side drives the write/pop/clear strobes; the FIFO drives data and status.
interface uart_rx_fifo_if #(
  parameter int DBIT       = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr;
  logic [DBIT-1:0]       w_data;
  logic                  rd;
  logic                  clr_ovf;
  logic [DBIT-1:0]       r_data;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  overflow;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output wr, w_data, rd, clr_ovf,
    input  r_data, empty, full, almost_full, overflow, count
  );

  modport slave (
    input  wr, w_data, rd, clr_ovf,
    output r_data, empty, full, almost_full, overflow, count
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO behind the UART receiver: first-word-fall-through head,
// occupancy count, empty/full/almost-full flags and a sticky overflow flag.
module uart_rx_fifo #(
  parameter int DBIT       = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12
) (
  input logic          clk,
  input logic          reset,
  uart_rx_fifo_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);

  logic [DBIT-1:0]       mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;

  logic empty_s, full_s;
  logic rd_eff, we;

  always_comb begin
    empty_s = (count_q == '0);
    full_s  = (count_q == DEPTH_C);
    rd_eff  = bus.rd & ~empty_s;
    // A pop on the same edge frees the slot, so writing while full is allowed then.
    we      = bus.wr & (~full_s | rd_eff);
  end

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (we)     w_ptr_d = w_ptr_q + 1'b1;
    if (rd_eff) r_ptr_d = r_ptr_q + 1'b1;

    case ({we, rd_eff})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A newly dropped write takes priority over a clear request.
    if (bus.wr & full_s & ~bus.rd) begin
      ovf_d = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is deliberately not reset; the head word is don't-care while empty.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[w_ptr_q] <= bus.w_data;
    end
  end

  assign bus.r_data      = mem_q[r_ptr_q];
  assign bus.empty       = empty_s;
  assign bus.full        = full_s;
  assign bus.almost_full = (count_q >= AF_C);
  assign bus.overflow    = ovf_q;
  assign bus.count       = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DBIT = 8;
  localparam int AW   = 4;
  localparam int AFL  = 12;
  localparam int DEP  = 1 << AW;

  logic clk;
  logic reset;

  uart_rx_fifo_if #(.DBIT(DBIT), .ADDR_WIDTH(AW)) bus ();

  uart_rx_fifo #(.DBIT(DBIT), .ADDR_WIDTH(AW), .AF_LEVEL(AFL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  logic [7:0] mq[$];
  logic       m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_model();
    check_eq("empty", 32'(bus.empty), 32'(mq.size() == 0));
    check_eq("full", 32'(bus.full), 32'(mq.size() == DEP));
    check_eq("almost_full", 32'(bus.almost_full), 32'(mq.size() >= AFL));
    check_eq("overflow", 32'(bus.overflow), 32'(m_ovf));
    check_eq("count", 32'(bus.count), 32'(mq.size()));
    if (mq.size() != 0) check_eq("r_data", 32'(bus.r_data), 32'(mq[0]));
  endtask

  // One clock with the given strobes; the model is advanced from pre-edge state.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic c);
    bit m_empty, m_full, r_eff, w_eff;
    bus.wr = w; bus.w_data = d; bus.rd = r; bus.clr_ovf = c;
    @(posedge clk);
    m_empty = (mq.size() == 0);
    m_full  = (mq.size() == DEP);
    r_eff   = r && !m_empty;
    w_eff   = w && (!m_full || r_eff);
    if (r_eff) void'(mq.pop_front());
    if (w_eff) mq.push_back(d);
    if (w && m_full && !r) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    #1;
    bus.wr = 1'b0; bus.rd = 1'b0; bus.clr_ovf = 1'b0;
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    check_model();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.wr = 1'b0; bus.w_data = '0; bus.rd = 1'b0; bus.clr_ovf = 1'b0;
    reset = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    check_eq("rst_empty", 32'(bus.empty), 32'd1);
    check_eq("rst_count", 32'(bus.count), 32'd0);

    // Single byte in and out.
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    check_eq("single_data", 32'(bus.r_data), 32'hA5);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("single_empty", 32'(bus.empty), 32'd1);

    // Fill in order; almost_full first appears at the 12th write.
    for (int i = 0; i < DEP; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == AFL - 2) check_eq("af_before", 32'(bus.almost_full), 32'd0);
      if (i == AFL - 1) check_eq("af_at_12", 32'(bus.almost_full), 32'd1);
    end
    check_eq("fill_full", 32'(bus.full), 32'd1);

    // Dropped write sets sticky overflow; clear takes it down.
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    check_eq("ovf_set", 32'(bus.overflow), 32'd1);
    check_eq("ovf_count", 32'(bus.count), 32'd16);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("ovf_sticky", 32'(bus.overflow), 32'd1);
    // Clear coinciding with another dropped write: set wins.
    cycle(1'b1, 8'hEE, 1'b0, 1'b1);
    check_eq("ovf_set_wins", 32'(bus.overflow), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("ovf_clr", 32'(bus.overflow), 32'd0);

    // Simultaneous write+pop while full keeps count at 16.
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    check_eq("sim_full_count", 32'(bus.count), 32'd16);
    check_eq("sim_full_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 1; i < DEP; i++) begin
      check_eq("order", 32'(bus.r_data), 32'(i));
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check_eq("last_55", 32'(bus.r_data), 32'h55);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("drain_empty", 32'(bus.empty), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);  // pop while empty is ignored
    check_eq("underflow_count", 32'(bus.count), 32'd0);

    // Simultaneous write+pop while empty: only the write happens.
    cycle(1'b1, 8'h33, 1'b1, 1'b0);
    check_eq("sim_empty_count", 32'(bus.count), 32'd1);
    check_eq("sim_empty_data", 32'(bus.r_data), 32'h33);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Pointer wrap.
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("pre_rst_count", 32'(bus.count), 32'd5);

    // Mid-cycle asynchronous reset clears state before the next edge.
    do_reset();
    check_eq("async_rst_empty", 32'(bus.empty), 32'd1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(99) < 55), 8'($urandom), ($urandom_range(99) < 45),
            ($urandom_range(99) < 5));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
